// File: rtl/ifetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register; single-outstanding imem req/ack.
// Optional one-entry stall buffer (S_HOLD) enabled by defining IFETCH_BUF_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_inst_o
);

`ifdef IFETCH_BUF_EN
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DRAIN, S_HOLD} state_t;
  logic [31:0] buf_pc_q;
  logic [31:0] buf_inst_q;
`else
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DRAIN} state_t;
`endif

  state_t      state_q;
  logic        req_q;
  logic [31:0] pc_q;
  logic [31:0] redir_q;
  logic        valid_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        xfer;

  assign xfer          = req_q & imem_ack_i;
  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign if_id_valid_o = valid_q;
  assign if_id_pc_o    = id_pc_q;
  assign if_id_inst_o  = id_inst_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_BOOT;
      req_q     <= 1'b0;
      pc_q      <= RESET_PC;
      redir_q   <= RESET_PC;
      valid_q   <= 1'b0;
      id_pc_q   <= RESET_PC;
      id_inst_q <= NOP_INST;
`ifdef IFETCH_BUF_EN
      buf_pc_q   <= RESET_PC;
      buf_inst_q <= NOP_INST;
`endif
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          if (redirect_i) pc_q <= redirect_pc_i;
        end

        S_FETCH: begin
          if (redirect_i) begin
            // Redirect beats stall; an in-flight request must still be drained.
            valid_q   <= 1'b0;
            id_pc_q   <= pc_q;
            id_inst_q <= NOP_INST;
            if (req_q && !imem_ack_i) begin
              redir_q <= redirect_pc_i;
              state_q <= S_DRAIN;
            end else begin
              pc_q <= redirect_pc_i;
            end
          end else if (xfer && !stall_i) begin
            valid_q   <= 1'b1;
            id_pc_q   <= pc_q;
            id_inst_q <= imem_rdata_i;
            pc_q      <= pc_q + 32'd4;
          end else if (xfer) begin
`ifdef IFETCH_BUF_EN
            buf_pc_q   <= pc_q;
            buf_inst_q <= imem_rdata_i;
            pc_q       <= pc_q + 32'd4;
            req_q      <= 1'b0;
            state_q    <= S_HOLD;
`endif
          end else if (!stall_i) begin
            valid_q   <= 1'b0;
            id_pc_q   <= pc_q;
            id_inst_q <= NOP_INST;
          end
        end

        S_DRAIN: begin
          valid_q   <= 1'b0;
          id_pc_q   <= pc_q;
          id_inst_q <= NOP_INST;
          if (redirect_i) redir_q <= redirect_pc_i;
          if (imem_ack_i) begin
            pc_q    <= redirect_i ? redirect_pc_i : redir_q;
            state_q <= S_FETCH;
          end
        end

`ifdef IFETCH_BUF_EN
        S_HOLD: begin
          if (redirect_i) begin
            valid_q   <= 1'b0;
            id_pc_q   <= pc_q;
            id_inst_q <= NOP_INST;
            pc_q      <= redirect_pc_i;
            req_q     <= 1'b1;
            state_q   <= S_FETCH;
          end else if (!stall_i) begin
            valid_q   <= 1'b1;
            id_pc_q   <= buf_pc_q;
            id_inst_q <= buf_inst_q;
            req_q     <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
`endif

        default: begin
          state_q <= S_BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed table-driven bench for ifetch_unit; handles both IFETCH_BUF_EN builds.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ack = 1'b0;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    bit          stall;
    bit          redir;
    logic [31:0] rpc;
    bit          ack;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    bit          chk_pc;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[$];
  vec_t bvecs[$];

  ifetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_rdata_i(rdata), .if_id_valid_o(valid),
    .if_id_pc_o(id_pc), .if_id_inst_o(id_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  assign rdata = f(addr);

  function automatic vec_t mk(bit s, bit r, logic [31:0] rp, bit a, bit eq,
                              logic [31:0] ea, bit ev, bit cp, logic [31:0] ep,
                              logic [31:0] ei);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp; v.ack = a; v.req = eq; v.addr = ea;
    v.valid = ev; v.chk_pc = cp; v.pc = ep; v.inst = ei;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, bit eq, logic [31:0] ea, bit ev, bit cp,
                         logic [31:0] ep, logic [31:0] ei);
    chk({tag, "_req"}, {31'd0, req}, {31'd0, eq});
    chk({tag, "_addr"}, addr, ea);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, ev});
    if (cp) chk({tag, "_pc"}, id_pc, ep);
    chk({tag, "_inst"}, id_inst, ei);
  endtask

  task automatic apply(vec_t v, string tag);
    stall = v.stall; redirect = v.redir; redirect_pc = v.rpc; ack = v.ack;
    @(posedge clk);
    #1;
    chk_all(tag, v.req, v.addr, v.valid, v.chk_pc, v.pc, v.inst);
  endtask

  initial begin
    // Main stream: boot, steady fetch, stall, redirects, drain, wrap.
    vecs.push_back(mk(0,0,0,1, 1,32'h0,0,1,32'h0,NOP));
    vecs.push_back(mk(0,0,0,1, 1,32'h4,1,1,32'h0,f(32'h0)));
    vecs.push_back(mk(0,0,0,1, 1,32'h8,1,1,32'h4,f(32'h4)));
    vecs.push_back(mk(0,0,0,1, 1,32'hC,1,1,32'h8,f(32'h8)));
    for (int i = 0; i < 3; i++) begin
`ifdef IFETCH_BUF_EN
      vecs.push_back(mk(1,0,0,1, 0,32'h10,1,1,32'h8,f(32'h8)));
`else
      vecs.push_back(mk(1,0,0,1, 1,32'hC,1,1,32'h8,f(32'h8)));
`endif
    end
    vecs.push_back(mk(0,0,0,1, 1,32'h10,1,1,32'hC,f(32'hC)));
    vecs.push_back(mk(0,0,0,1, 1,32'h14,1,1,32'h10,f(32'h10)));
    vecs.push_back(mk(0,1,32'h100,1, 1,32'h100,0,0,0,NOP));
    vecs.push_back(mk(0,0,0,1, 1,32'h104,1,1,32'h100,f(32'h100)));
    vecs.push_back(mk(0,1,32'h20,1, 1,32'h20,0,0,0,NOP));
    vecs.push_back(mk(0,1,32'h200,0, 1,32'h20,0,0,0,NOP));
    vecs.push_back(mk(0,0,0,0, 1,32'h20,0,0,0,NOP));
    vecs.push_back(mk(0,0,0,1, 1,32'h200,0,0,0,NOP));
    vecs.push_back(mk(0,0,0,1, 1,32'h204,1,1,32'h200,f(32'h200)));
    vecs.push_back(mk(0,1,32'h300,0, 1,32'h204,0,0,0,NOP));
    vecs.push_back(mk(0,1,32'h400,0, 1,32'h204,0,0,0,NOP));
    vecs.push_back(mk(0,1,32'h500,1, 1,32'h500,0,0,0,NOP));
    vecs.push_back(mk(0,0,0,1, 1,32'h504,1,1,32'h500,f(32'h500)));
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,1, 1,32'hFFFF_FFFC,0,0,0,NOP));
    vecs.push_back(mk(0,0,0,1, 1,32'h0,1,1,32'hFFFF_FFFC,f(32'hFFFF_FFFC)));
    vecs.push_back(mk(0,0,0,1, 1,32'h4,1,1,32'h0,f(32'h0)));
    vecs.push_back(mk(1,0,0,0, 1,32'h4,1,1,32'h0,f(32'h0)));
    vecs.push_back(mk(1,1,32'h80,0, 1,32'h4,0,0,0,NOP));
    vecs.push_back(mk(0,0,0,1, 1,32'h80,0,0,0,NOP));
    vecs.push_back(mk(0,0,0,0, 1,32'h80,0,1,32'h80,NOP));
    vecs.push_back(mk(0,1,32'h600,0, 1,32'h80,0,0,0,NOP));

    // Stall buffer: capture at 0x40, release, then redirect out of S_HOLD.
    bvecs.push_back(mk(0,1,32'h40,1, 1,32'h40,0,0,0,NOP));
    bvecs.push_back(mk(1,0,0,1, 0,32'h44,0,0,0,NOP));
    bvecs.push_back(mk(1,0,0,1, 0,32'h44,0,0,0,NOP));
    bvecs.push_back(mk(0,0,0,1, 1,32'h44,1,1,32'h40,f(32'h40)));
    bvecs.push_back(mk(0,0,0,1, 1,32'h48,1,1,32'h44,f(32'h44)));
    bvecs.push_back(mk(1,0,0,1, 0,32'h4C,1,1,32'h44,f(32'h44)));
    bvecs.push_back(mk(1,1,32'h700,1, 1,32'h700,0,0,0,NOP));
    bvecs.push_back(mk(0,0,0,1, 1,32'h704,1,1,32'h700,f(32'h700)));

    #12;
    chk_all("reset", 0, 32'h0, 0, 1, 32'h0, NOP);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("v%0d", i));

    // Now in S_DRAIN with a request outstanding: async reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk_all("areset", 0, 32'h0, 0, 1, 32'h0, NOP);
    @(posedge clk);
    #1;
    chk_all("areset_hold", 0, 32'h0, 0, 1, 32'h0, NOP);
    rst = 1'b0;
    stall = 1'b0; redirect = 1'b0; ack = 1'b1;
    @(posedge clk);
    #1;
    chk_all("reboot", 1, 32'h0, 0, 1, 32'h0, NOP);
    @(posedge clk);
    #1;
    chk_all("refetch", 1, 32'h4, 1, 1, 32'h0, f(32'h0));

`ifdef IFETCH_BUF_EN
    for (int i = 0; i < bvecs.size(); i++)
      apply(bvecs[i], $sformatf("buf%0d", i));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
